// File: rtl/sb_compare_ctrl.sv
// In-order scoreboard controller: buffers expected beats in a FIFO, compares each actual beat
// against the FIFO head, keeps pass/fail/missing counts and sequences IDLE/RUN/DRAIN/DONE.
module sb_compare_ctrl #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       end_test_i,
  input  logic                       exp_valid_i,
  output logic                       exp_ready_o,
  input  logic [DATA_W-1:0]          exp_data_i,
  input  logic                       act_valid_i,
  output logic                       act_ready_o,
  input  logic [DATA_W-1:0]          act_data_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [CNT_W-1:0]           pass_cnt_o,
  output logic [CNT_W-1:0]           fail_cnt_o,
  output logic [CNT_W-1:0]           missing_cnt_o,
  output logic                       mismatch_o,
  output logic [DATA_W-1:0]          mis_exp_o,
  output logic [DATA_W-1:0]          mis_act_o,
  output logic                       timeout_err_o,
  output logic                       result_pass_o
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT-1);

  // IDLE: wait start | RUN: accept exp+act | DRAIN: act only, watchdog armed | DONE: verdict held
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [WW-1:0]     wd_q;
  logic [CNT_W-1:0]  pass_q, fail_q, missing_q;
  logic              mismatch_q, timeout_q;
  logic [DATA_W-1:0] mis_exp_q, mis_act_q;
  logic              push, pop, head_eq;

  assign exp_ready_o = (state_q == S_RUN) && (level_q != FULL_LVL);
  assign act_ready_o = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (level_q != '0);
  assign push        = exp_valid_i && exp_ready_o;
  assign pop         = act_valid_i && act_ready_o;
  assign head_eq     = (mem_q[rd_ptr_q] == act_data_i);

  assign level_o       = level_q;
  assign busy_o        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o        = (state_q == S_DONE);
  assign pass_cnt_o    = pass_q;
  assign fail_cnt_o    = fail_q;
  assign missing_cnt_o = missing_q;
  assign mismatch_o    = mismatch_q;
  assign mis_exp_o     = mis_exp_q;
  assign mis_act_o     = mis_act_q;
  assign timeout_err_o = timeout_q;
  assign result_pass_o = done_o && (fail_q == '0) && !timeout_q;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= exp_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wd_q       <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      missing_q  <= '0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
      mis_exp_q  <= '0;
      mis_act_q  <= '0;
    end else begin
      mismatch_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        if (head_eq) begin
          if (pass_q != '1) pass_q <= pass_q + 1'b1;
        end else begin
          if (fail_q != '1) fail_q <= fail_q + 1'b1;
          mismatch_q <= 1'b1;
          mis_exp_q  <= mem_q[rd_ptr_q];
          mis_act_q  <= act_data_i;
        end
      end
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q   <= S_RUN;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            missing_q <= '0;
            timeout_q <= 1'b0;
            mis_exp_q <= '0;
            mis_act_q <= '0;
          end
        end
        S_RUN: begin
          if (end_test_i) begin
            state_q <= S_DRAIN;
            wd_q    <= '0;
          end
        end
        S_DRAIN: begin
          if (level_q == '0) begin
            state_q <= S_DONE;
          end else if (pop) begin
            wd_q <= '0;
          end else if (wd_q == WD_LAST) begin
            // abort: unmatched expected entries are counted and discarded
            state_q   <= S_DONE;
            timeout_q <= 1'b1;
            missing_q <= CNT_W'(level_q);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sb_compare_ctrl.sv
// Bench for sb_compare_ctrl: a scoreboard queue of accepted expected beats predicts every
// compare outcome and mismatch pulse; directed sequences cover full/empty, drain and reset.
module tb_sb_compare_ctrl;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;

  logic              clk_i, rst_i, start_i, end_test_i;
  logic              exp_valid_i, exp_ready_o, act_valid_i, act_ready_o;
  logic [DATA_W-1:0] exp_data_i, act_data_i;
  logic [4:0]        level_o;
  logic              busy_o, done_o, mismatch_o, timeout_err_o, result_pass_o;
  logic [CNT_W-1:0]  pass_cnt_o, fail_cnt_o, missing_cnt_o;
  logic [DATA_W-1:0] mis_exp_o, mis_act_o;

  sb_compare_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .end_test_i(end_test_i),
    .exp_valid_i(exp_valid_i), .exp_ready_o(exp_ready_o), .exp_data_i(exp_data_i),
    .act_valid_i(act_valid_i), .act_ready_o(act_ready_o), .act_data_i(act_data_i),
    .level_o(level_o), .busy_o(busy_o), .done_o(done_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o), .missing_cnt_o(missing_cnt_o),
    .mismatch_o(mismatch_o), .mis_exp_o(mis_exp_o), .mis_act_o(mis_act_o),
    .timeout_err_o(timeout_err_o), .result_pass_o(result_pass_o)
  );

  int                n_tot = 0;
  int                n_bad = 0;
  logic [DATA_W-1:0] sb_q[$];
  logic [15:0]       mis_q[$];
  int                m_pass, m_fail;
  bit                live;
  logic [DATA_W-1:0] hd;
  logic [15:0]       pr;
  int                ncyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // scoreboard: learn handshakes at the edge, compare DUT state just after it
  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (exp_valid_i && exp_ready_o) sb_q.push_back(exp_data_i);
      if (act_valid_i && act_ready_o && sb_q.size() > 0) begin
        hd = sb_q.pop_front();
        if (hd == act_data_i) m_pass++;
        else begin
          m_fail++;
          mis_q.push_back({hd, act_data_i});
        end
      end
    end
    #1;
    if (live && !rst_i) begin
      check("level", level_o, sb_q.size());
      check("pass_cnt", pass_cnt_o, m_pass);
      check("fail_cnt", fail_cnt_o, m_fail);
      if (mis_q.size() > 0) begin
        pr = mis_q.pop_front();
        check("mis_pulse", mismatch_o, 1);
        check("mis_exp", mis_exp_o, pr[15:8]);
        check("mis_act", mis_act_o, pr[7:0]);
      end else begin
        check("mis_quiet", mismatch_o, 0);
      end
    end
  end

  task automatic clr_model();
    sb_q.delete();
    mis_q.delete();
    m_pass = 0;
    m_fail = 0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    clr_model();
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d);
    exp_valid_i = 1'b1;
    exp_data_i  = d;
    @(negedge clk_i);
    exp_valid_i = 1'b0;
  endtask

  task automatic send_act(input logic [DATA_W-1:0] d);
    act_valid_i = 1'b1;
    act_data_i  = d;
    @(negedge clk_i);
    act_valid_i = 1'b0;
  endtask

  task automatic end_t();
    end_test_i = 1'b1;
    @(negedge clk_i);
    end_test_i = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("done_reached", done_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_i = 1'b1; start_i = 1'b0; end_test_i = 1'b0;
    exp_valid_i = 1'b0; exp_data_i = '0; act_valid_i = 1'b0; act_data_i = '0;
    live = 1'b0;
    clr_model();
    repeat (2) @(negedge clk_i);
    check("rst_level", level_o, 0);
    check("rst_flags", {busy_o, done_o, mismatch_o, timeout_err_o, result_pass_o}, 0);
    check("rst_ready", {exp_ready_o, act_ready_o}, 0);
    check("rst_cnts", {pass_cnt_o, fail_cnt_o}, 0);
    check("rst_mis", {missing_cnt_o, mis_exp_o, mis_act_o}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_ready", {exp_ready_o, act_ready_o}, 0);
    live = 1'b1;

    // basic all-pass sequence
    do_start();
    check("t1_busy", busy_o, 1);
    push_exp(8'h11); push_exp(8'h22); push_exp(8'h33);
    send_act(8'h11); send_act(8'h22); send_act(8'h33);
    end_t();
    wait_done(ncyc);
    check("t1_pass", pass_cnt_o, 3);
    check("t1_fail", fail_cnt_o, 0);
    check("t1_result", result_pass_o, 1);
    check("t1_busy_off", busy_o, 0);

    // single mismatch
    do_start();
    check("t2_cleared", pass_cnt_o, 0);
    push_exp(8'hA5);
    send_act(8'h5A);
    check("t2_pulse", mismatch_o, 1);
    check("t2_mis_exp", mis_exp_o, 8'hA5);
    check("t2_mis_act", mis_act_o, 8'h5A);
    @(negedge clk_i);
    check("t2_pulse_end", mismatch_o, 0);
    check("t2_held", mis_act_o, 8'h5A);
    end_t();
    wait_done(ncyc);
    check("t2_fail", fail_cnt_o, 1);
    check("t2_result", result_pass_o, 0);

    // fill to full, pop at full, push+pop at 15, then drain with random mismatches
    do_start();
    for (int i = 0; i < DEPTH; i++) push_exp(8'($urandom));
    check("t3_full_level", level_o, DEPTH);
    check("t3_full_ready", exp_ready_o, 0);
    exp_valid_i = 1'b1; exp_data_i = 8'hEE;
    act_valid_i = 1'b1; act_data_i = sb_q[0];
    @(negedge clk_i);
    exp_valid_i = 1'b0; act_valid_i = 1'b0;
    check("t3_pop_level", level_o, DEPTH - 1);
    check("t3_ready_back", exp_ready_o, 1);
    exp_valid_i = 1'b1; exp_data_i = 8'($urandom);
    act_valid_i = 1'b1; act_data_i = sb_q[0] ^ 8'h01;
    @(negedge clk_i);
    exp_valid_i = 1'b0; act_valid_i = 1'b0;
    check("t3_pushpop_level", level_o, DEPTH - 1);
    for (int i = 0; i < 40 && sb_q.size() > 0; i++) begin
      act_valid_i = 1'b1;
      act_data_i  = ($urandom_range(0, 1) == 1) ? sb_q[0] : ~sb_q[0];
      @(negedge clk_i);
    end
    act_valid_i = 1'b0;
    end_t();
    wait_done(ncyc);
    check("t3_total", pass_cnt_o + fail_cnt_o, DEPTH + 1);
    check("t3_result", result_pass_o, (m_fail == 0) ? 1 : 0);

    // act on empty FIFO, then drain watchdog abort
    do_start();
    act_valid_i = 1'b1; act_data_i = 8'h00;
    check("t5_act_ready", act_ready_o, 0);
    @(negedge clk_i);
    act_valid_i = 1'b0;
    check("t5_cnts", {pass_cnt_o, fail_cnt_o}, 0);
    push_exp(8'd1); push_exp(8'd2); push_exp(8'd3);
    send_act(8'd1);
    end_t();
    live = 1'b0;
    wait_done(ncyc);
    check("t4_cycles", ncyc, TIMEOUT);
    check("t4_timeout", timeout_err_o, 1);
    check("t4_missing", missing_cnt_o, 2);
    check("t4_level", level_o, 0);
    check("t4_result", result_pass_o, 0);
    check("t4_pass", pass_cnt_o, 1);
    sb_q.delete();
    live = 1'b1;

    // restart clears the timeout, then async reset mid-run
    do_start();
    check("t6_tmo_clr", timeout_err_o, 0);
    check("t6_miss_clr", missing_cnt_o, 0);
    for (int i = 0; i < 6; i++) push_exp(8'(i + 8'h40));
    send_act(8'h40);
    check("t6_level5", level_o, 5);
    live = 1'b0;
    rst_i = 1'b1;
    #1;
    check("t6_level", level_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_cnts", {pass_cnt_o, fail_cnt_o, missing_cnt_o}, 0);
    check("t6_ready", {exp_ready_o, act_ready_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    clr_model();
    @(negedge clk_i);
    check("t6_idle", {busy_o, done_o}, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
